// File: rtl/phy_reg_allocator_pkg.sv
// Shared constants and types for the physical register free-list allocator.
package phy_reg_allocator_pkg;

  localparam int NUM_PHY_REGS_DEF = 64;
  localparam int NUM_ARCH_REGS    = 32;
  localparam int NUM_SICS_DEF     = 2;
  localparam int PRW_DEF          = $clog2(NUM_PHY_REGS_DEF);

  typedef logic [PRW_DEF-1:0] phy_reg_t;

  // Number of registers that circulate through the free pool.
  function automatic int free_cap(input int num_phy, input int num_arch);
    return num_phy - num_arch;
  endfunction

endpackage

// File: rtl/phy_reg_allocator_if.sv
// Allocate / release / status bundle between the allocator and its requesters.
//
// Handshake: alloc_req[s] is a per-cycle request with no queuing. When
// alloc_gnt[s] is high in the same cycle, the register in alloc_pr[s] is
// owned by requester s from the next clock edge on. A request that is not
// granted is simply dropped; the requester retries by holding alloc_req[s].
// rel_valid[s] is unconditional: the pool always accepts a release, and
// the released index becomes grantable from the following cycle.
interface phy_reg_allocator_if #(
  parameter int NUM_SICS = 2,
  parameter int PRW      = 6,
  parameter int FCW      = 6
);
  logic [NUM_SICS-1:0]          alloc_req;
  logic [NUM_SICS-1:0]          alloc_gnt;
  logic [NUM_SICS-1:0][PRW-1:0] alloc_pr;
  logic [NUM_SICS-1:0]          rf_alloc_wen;
  logic [NUM_SICS-1:0][PRW-1:0] rf_alloc_pr;
  logic [NUM_SICS-1:0]          rel_valid;
  logic [NUM_SICS-1:0][PRW-1:0] rel_pr;
  logic [FCW-1:0]               free_count;
  logic                         pool_empty;

  modport master (
    output alloc_req, rel_valid, rel_pr,
    input  alloc_gnt, alloc_pr, rf_alloc_wen, rf_alloc_pr, free_count, pool_empty
  );

  modport slave (
    input  alloc_req, rel_valid, rel_pr,
    output alloc_gnt, alloc_pr, rf_alloc_wen, rf_alloc_pr, free_count, pool_empty
  );
endinterface

// File: rtl/phy_reg_allocator_rr_grant_scan.sv
// Round-robin scan: ranks requesters starting at rr_ptr and grants the first
// `count` of them. Purely combinational so it can sit in front of any pool.
module phy_reg_allocator_rr_grant_scan #(
  parameter int N   = 2,
  parameter int RRW = 1,
  parameter int CW  = 6
) (
  input  logic [N-1:0]         req,
  input  logic [RRW-1:0]       rr_ptr,
  input  logic [CW-1:0]        count,
  output logic [N-1:0]         gnt,
  output logic [N-1:0][CW-1:0] rank
);

  // Walk ports in rotated order; k counts requesters seen so far.
  always_comb begin
    int k;
    int idx;
    gnt  = '0;
    rank = '0;
    k    = 0;
    idx  = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(rr_ptr) + i) % N;
      if (req[idx]) begin
        rank[idx] = CW'(k);
        if (k < int'(count)) gnt[idx] = 1'b1;
        k = k + 1;
      end
    end
  end

endmodule

// File: rtl/phy_reg_allocator.sv
// Free-list manager for the physical register file: a circular FIFO of free
// indices, zero-latency multi-port grant, and multi-port release.
module phy_reg_allocator
  import phy_reg_allocator_pkg::*;
#(
  parameter int NUM_PHY_REGS = NUM_PHY_REGS_DEF,
  parameter int NUM_SICS     = NUM_SICS_DEF,
  parameter int NUM_ARCH     = NUM_ARCH_REGS
) (
  input logic               clk,
  input logic               rst_n,
  phy_reg_allocator_if.slave bus
);

  localparam int PRW = $clog2(NUM_PHY_REGS);
  localparam int F   = free_cap(NUM_PHY_REGS, NUM_ARCH);
  localparam int PW  = (F > 1) ? $clog2(F) : 1;
  localparam int CW  = $clog2(F + 1);
  localparam int RRW = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1;

  logic [PRW-1:0]              fifo [F];
  logic [PW-1:0]               head, tail;
  logic [CW-1:0]               count;
  logic [NUM_PHY_REGS-1:0]     in_pool;
  logic [RRW-1:0]              rr_ptr, rr_next;

  logic [NUM_SICS-1:0]          gnt;
  logic [NUM_SICS-1:0][CW-1:0]  rank;
  logic [NUM_SICS-1:0][PRW-1:0] gnt_pr;
  logic [NUM_SICS-1:0][PW-1:0]  rel_addr;
  int                           ngnt, nrel, last_gnt;
  logic                         denied;

  function automatic logic [PW-1:0] ring_add(input logic [PW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    return PW'(sum % F);
  endfunction

  phy_reg_allocator_rr_grant_scan #(.N(NUM_SICS), .RRW(RRW), .CW(CW)) u_scan (
    .req    (bus.alloc_req),
    .rr_ptr (rr_ptr),
    .count  (count),
    .gnt    (gnt),
    .rank   (rank)
  );

  // Grant outputs: k-th granted port takes the k-th entry past head.
  always_comb begin
    for (int s = 0; s < NUM_SICS; s++) begin
      gnt_pr[s] = fifo[ring_add(head, int'(rank[s]))];
    end
    bus.alloc_gnt    = rst_n ? gnt : '0;
    bus.alloc_pr     = gnt_pr;
    bus.rf_alloc_wen = rst_n ? gnt : '0;
    bus.rf_alloc_pr  = gnt_pr;
    bus.free_count   = count;
    bus.pool_empty   = (count == '0);
  end

  // Per-cycle bookkeeping: release slots, grant/release totals, next rr_ptr.
  always_comb begin
    nrel     = 0;
    ngnt     = 0;
    last_gnt = 0;
    rel_addr = '0;
    for (int s = 0; s < NUM_SICS; s++) begin
      rel_addr[s] = ring_add(tail, nrel);
      if (bus.rel_valid[s]) nrel = nrel + 1;
      if (gnt[s]) ngnt = ngnt + 1;
    end
    for (int s = 0; s < NUM_SICS; s++) begin
      if (gnt[s] && (int'(rank[s]) == ngnt - 1)) last_gnt = s;
    end
    denied = |(bus.alloc_req & ~gnt);
    if (!denied)       rr_next = rr_ptr;
    else if (ngnt == 0) rr_next = RRW'((int'(rr_ptr) + 1) % NUM_SICS);
    else               rr_next = RRW'((last_gnt + 1) % NUM_SICS);
  end

  // Pool state: reset refills the ring with every non-reserved register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < F; i++) fifo[i] <= PRW'(NUM_ARCH + i);
      head    <= '0;
      tail    <= '0;
      count   <= CW'(F);
      for (int p = 0; p < NUM_PHY_REGS; p++) in_pool[p] <= (p >= NUM_ARCH);
      rr_ptr  <= '0;
    end else begin
      for (int s = 0; s < NUM_SICS; s++) begin
        if (bus.rel_valid[s]) fifo[rel_addr[s]] <= bus.rel_pr[s];
      end
      head   <= ring_add(head, ngnt);
      tail   <= ring_add(tail, nrel);
      count  <= CW'(int'(count) + nrel - ngnt);
      for (int s = 0; s < NUM_SICS; s++) begin
        if (gnt[s]) in_pool[gnt_pr[s]] <= 1'b0;
      end
      for (int s = 0; s < NUM_SICS; s++) begin
        if (bus.rel_valid[s]) in_pool[bus.rel_pr[s]] <= 1'b1;
      end
      rr_ptr <= rr_next;
    end
  end

`ifndef SYNTHESIS
  // Illegal release traffic stops simulation immediately.
  always @(posedge clk) begin
    if (rst_n) begin
      for (int s = 0; s < NUM_SICS; s++) begin
        if (bus.rel_valid[s]) begin
          if (int'(bus.rel_pr[s]) < NUM_ARCH)
            $fatal(1, "phy_reg_allocator: release of reserved pr %0d", bus.rel_pr[s]);
          if (in_pool[bus.rel_pr[s]])
            $fatal(1, "phy_reg_allocator: double free of pr %0d", bus.rel_pr[s]);
          for (int t = s + 1; t < NUM_SICS; t++) begin
            if (bus.rel_valid[t] && (bus.rel_pr[t] == bus.rel_pr[s]))
              $fatal(1, "phy_reg_allocator: pr %0d released on two ports", bus.rel_pr[s]);
          end
        end
      end
      if (int'(count) + nrel - ngnt > F)
        $fatal(1, "phy_reg_allocator: pool overflow");
    end
  end
`endif

endmodule

// File: tb/tb_phy_reg_allocator.sv
// Bench for phy_reg_allocator: directed scenarios plus random traffic against
// a queue-based model of the free pool.
module tb_phy_reg_allocator;
  import phy_reg_allocator_pkg::*;

  localparam int N   = 2;
  localparam int PRW = PRW_DEF;
  localparam int F   = free_cap(NUM_PHY_REGS_DEF, NUM_ARCH_REGS);
  localparam int FCW = $clog2(F + 1);
  localparam int W   = 16 + 1 + PRW;

  logic clk;
  logic rst_n;

  phy_reg_allocator_if #(.NUM_SICS(N), .PRW(PRW), .FCW(FCW)) bus ();

  phy_reg_allocator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model + scoreboard state ----------------
  int pool_q[$];
  int held_q[$];
  int rr;
  int cyc;
  logic [W-1:0] exp_q[$];
  int           fc_q[$];
  int tot;
  int bad;

  task automatic model_reset();
    pool_q.delete();
    held_q.delete();
    for (int i = NUM_ARCH_REGS; i < NUM_PHY_REGS_DEF; i++) pool_q.push_back(i);
    rr = 0;
    fc_q.delete();
    exp_q.delete();
  endtask

  // Assert reset with requests held high so the grant gating is observed.
  task automatic do_reset();
    rst_n         = 1'b0;
    bus.alloc_req = 2'b11;
    bus.rel_valid = '0;
    bus.rel_pr    = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic take_held(input int v);
    for (int i = 0; i < held_q.size(); i++) begin
      if (held_q[i] == v) begin
        held_q.delete(i);
        return;
      end
    end
  endtask

  // Drive one cycle of stimulus, push the model's expectations, advance.
  task automatic drive(input logic [1:0] req, input logic [1:0] rv, input int p0, input int p1);
    int avail, ng, last, s;
    logic denied;
    logic [1:0] gp;
    int gpr [N];
    logic [15:0] ct;
    bus.alloc_req = req;
    bus.rel_valid = rv;
    bus.rel_pr[0] = PRW'(p0);
    bus.rel_pr[1] = PRW'(p1);
    fc_q.push_back(pool_q.size());
    avail  = pool_q.size();
    ng     = 0;
    last   = 0;
    denied = 1'b0;
    gp     = '0;
    for (int i = 0; i < N; i++) begin
      gpr[i] = 0;
    end
    for (int i = 0; i < N; i++) begin
      s = (rr + i) % N;
      if (req[s]) begin
        if (ng < avail) begin
          gp[s]  = 1'b1;
          gpr[s] = pool_q[ng];
          ng     = ng + 1;
          last   = s;
        end else begin
          denied = 1'b1;
        end
      end
    end
    ct = cyc[15:0];
    for (int i = 0; i < N; i++) begin
      if (gp[i]) exp_q.push_back({ct, 1'(i), PRW'(gpr[i])});
    end
    for (int i = 0; i < ng; i++) held_q.push_back(pool_q.pop_front());
    if (rv[0]) pool_q.push_back(p0);
    if (rv[1]) pool_q.push_back(p1);
    if (denied) rr = (ng == 0) ? (rr + 1) % N : (last + 1) % N;
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    int e;
    logic [W-1:0] x;
    logic hit;
    if (!rst_n) begin
      tot = tot + 1;
      if (bus.alloc_gnt !== '0 || bus.rf_alloc_wen !== '0) begin
        bad = bad + 1;
        $display("FAIL reset_gnt: got gnt=%b wen=%b want 00", bus.alloc_gnt, bus.rf_alloc_wen);
      end
      tot = tot + 1;
      if (bus.free_count !== FCW'(F) || bus.pool_empty !== 1'b0) begin
        bad = bad + 1;
        $display("FAIL reset_count: got fc=%0d empty=%b want %0d 0", bus.free_count, bus.pool_empty, F);
      end
    end else begin
      tot = tot + 1;
      if (fc_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL fc_underflow: got fc=%0d with no expectation queued", bus.free_count);
      end else begin
        e = fc_q.pop_front();
        if (bus.free_count !== FCW'(e) || bus.pool_empty !== (e == 0)) begin
          bad = bad + 1;
          $display("FAIL free_count cyc=%0d: got fc=%0d empty=%b want %0d %b",
                   cyc, bus.free_count, bus.pool_empty, e, (e == 0));
        end
      end
      for (int s = 0; s < N; s++) begin
        hit = (exp_q.size() > 0) && (exp_q[0][W-1:W-16] == cyc[15:0]) && (exp_q[0][PRW] == 1'(s));
        tot = tot + 1;
        if (hit) begin
          x = exp_q.pop_front();
          if (bus.alloc_gnt[s] !== 1'b1 || bus.alloc_pr[s] !== x[PRW-1:0] ||
              bus.rf_alloc_wen[s] !== 1'b1 || bus.rf_alloc_pr[s] !== x[PRW-1:0]) begin
            bad = bad + 1;
            $display("FAIL grant cyc=%0d port=%0d: got gnt=%b pr=%0d wen=%b rfpr=%0d want gnt=1 pr=%0d",
                     cyc, s, bus.alloc_gnt[s], bus.alloc_pr[s], bus.rf_alloc_wen[s],
                     bus.rf_alloc_pr[s], x[PRW-1:0]);
          end
        end else if (bus.alloc_gnt[s] !== 1'b0 || bus.rf_alloc_wen[s] !== 1'b0) begin
          bad = bad + 1;
          $display("FAIL no_grant cyc=%0d port=%0d: got gnt=%b wen=%b pr=%0d want gnt=0",
                   cyc, s, bus.alloc_gnt[s], bus.rf_alloc_wen[s], bus.alloc_pr[s]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] rv;
    int p [N];
    int idx;
    tot = 0;
    bad = 0;
    cyc = 0;
    do_reset();

    // Both ports in the first cycle take 32 and 33.
    drive(2'b11, 2'b00, 0, 0);
    drive(2'b00, 2'b00, 0, 0);

    // Drain the whole pool from port 0, then one denied request.
    do_reset();
    for (int i = 0; i < F; i++) drive(2'b01, 2'b00, 0, 0);
    drive(2'b01, 2'b00, 0, 0);

    // Release into an empty pool: no bypass, grant on the next cycle.
    take_held(40);
    drive(2'b01, 2'b10, 0, 40);
    drive(2'b01, 2'b00, 0, 0);

    // One free entry, both ports asking, one release per cycle.
    take_held(41);
    drive(2'b00, 2'b01, 41, 0);
    for (int i = 0; i < 4; i++) begin
      take_held(42 + i);
      drive(2'b11, 2'b01, 42 + i, 0);
    end

    // Random traffic; releases come only from registers the model holds.
    for (int c = 0; c < 400; c++) begin
      rv = '0;
      for (int s = 0; s < N; s++) begin
        p[s] = 0;
        if (held_q.size() > 0 && $urandom_range(0, 1) == 1) begin
          idx     = $urandom_range(0, held_q.size() - 1);
          p[s]    = held_q[idx];
          held_q.delete(idx);
          rv[s]   = 1'b1;
        end
      end
      drive(2'(($urandom_range(0, 3))), rv, p[0], p[1]);
    end

    // Reset in the middle of allocation restores the full ring.
    do_reset();
    for (int i = 0; i < 10; i++) drive(2'b01, 2'b00, 0, 0);
    do_reset();
    drive(2'b01, 2'b00, 0, 0);
    drive(2'b10, 2'b00, 0, 0);

    tot = tot + 1;
    if (exp_q.size() != 0 || fc_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL leftover: got %0d grants and %0d counts unchecked want 0 0", exp_q.size(), fc_q.size());
    end
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/phy_reg_allocator.md
Name: phy_reg_allocator

Overview:
- Free-list manager and multi-port allocator for the physical register file.
- Hands out free physical registers (indices NUM_ARCH..NUM_PHY_REGS-1) to up to NUM_SICS requesters per cycle.
- Drives the register file's allocate port, so the granted register's valid bit clears on the next edge.
- Accepts recycled registers back into a circular free FIFO and round-robin arbitrates requesters when free entries are scarce.

Parameters:
- NUM_PHY_REGS, 64, total physical registers; PRW = $clog2(NUM_PHY_REGS).
- NUM_SICS, 2, number of requester/release port pairs.
- NUM_ARCH, 32, registers 0..NUM_ARCH-1 are reserved. They are never allocated or released. Free pool capacity F = NUM_PHY_REGS - NUM_ARCH.

Ports:
- Clocking and reset (already decided): reset rst_n, asynchronous, active-low; clock clk.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- alloc_req  in  [NUM_SICS] x 1  requester s wants one free physical register this cycle.
- alloc_gnt  out  [NUM_SICS] x 1  grant; combinational, same cycle as the request.
- alloc_pr  out  [NUM_SICS] x PRW  granted register index; meaningful only when alloc_gnt[s]=1.
- rf_alloc_wen  out  [NUM_SICS] x 1  to the register file's allocate-enable input; equals alloc_gnt.
- rf_alloc_pr  out  [NUM_SICS] x PRW  to the register file's allocate-index input; equals alloc_pr.
- rel_valid  in  [NUM_SICS] x 1  return one register to the pool.
- rel_pr  in  [NUM_SICS] x PRW  index being returned.
- free_count  out  $clog2(F+1)  registered number of free entries.
- pool_empty  out  1  free_count==0.

Behaviour:
- State:
  - fifo[F] of PRW entries.
  - head and tail pointers, each $clog2(F) bits, wrapping modulo F.
  - count.
  - in_pool bitmap [NUM_PHY_REGS].
  - rr_ptr of $clog2(NUM_SICS) bits (minimum 1 bit).
- Reset:
  - fifo[i] = NUM_ARCH+i; head = 0; tail = 0 (full ring); count = F.
  - in_pool[p] = (p >= NUM_ARCH); rr_ptr = 0.
  - Outputs: free_count = F, pool_empty = 0.
  - alloc_gnt / rf_alloc_wen forced to 0 while rst_n is low.
- Grant, combinational from registered state only:
  - Scan requesters starting at rr_ptr, wrapping.
  - The k-th requesting port (k = 0,1,...) is granted while k < count.
  - That port receives alloc_pr = fifo[(head+k) mod F].
  - Zero-latency grant. The register file sees allocate on the same edge.
- Registers released in cycle N are not grantable before cycle N+1. There is no release-to-grant bypass.
- Release:
  - Each rel_valid[s] pushes rel_pr[s] at tail+j, where j is the rank among asserted release ports in index order 0..NUM_SICS-1.
  - Sets in_pool.
- Update on every edge:
  - head += ngnt; tail += nrel (modulo F).
  - count = count + nrel - ngnt.
  - Clear in_pool for granted registers.
  - Simultaneous grant and release in the same cycle is legal.
- Fairness: if any request is denied in a cycle, rr_ptr <= (index of the last granted port + 1) mod NUM_SICS. If none was granted, rr_ptr <= rr_ptr + 1. Otherwise rr_ptr is unchanged.
- Empty: count==0 means no grants are issued and pool_empty=1. Requesters simply retry; there is no queuing.
- Simulation-only fatal checks:
  - release of pr < NUM_ARCH;
  - release of a register whose in_pool is already 1 (double free);
  - count + nrel - ngnt > F.
  - Two release ports naming the same pr in one cycle counts as a double free.
- Reset mid-operation restores the full initial pool. In-flight grants are discarded.
- free_count and pool_empty reflect registered count, i.e. before the current cycle's grants and releases.

Decomposition:
- Shared package holds:
  - NUM_ARCH_REGS constant;
  - typedef phy_reg_t as logic [PRW-1:0];
  - a function computing F.
- One natural sub-module: rr_grant_scan. It is combinational: inputs alloc_req, rr_ptr and count; outputs the grant vector and per-port rank k. It is reusable by other multi-SIC arbiters.

Test Plan:
- Reset, then both ports request in cycle 1 -> gnt=2'b11, alloc_pr[0]=32, alloc_pr[1]=33; next cycle free_count=30.
- 32 single allocations from port 0 -> prs 32..63 in order, then pool_empty=1 and the 33rd request gets gnt=0.
- Pool empty; rel_valid[1]=1 with rel_pr=40 in cycle N, port 0 requesting -> no grant in N; gnt with pr=40 in N+1.
- count=1 and both ports request for 4 cycles while one register is released back each cycle -> grants alternate port0, port1, port0, port1.
- Release pr=5, or release pr=33 while it is still in the pool -> simulation $fatal.
- Assert rst_n low mid-stream after 10 allocations -> free_count=32 and the next grant returns pr=32.
